grant_queue: RTL and testbench
==============================

Name: grant_queue

Overview:
- Downstream consumer of the two-requester arbiter. Samples the arbiter's grant_1/grant_2 together with each requester's request and payload.
- Enqueues the winning payload into a shared FIFO, tagged with its source, and presents it to the next pipeline stage over a valid/ready interface.
- Honours the pipeline's global stall.
- Reports per-source accept counts and flags illegal double grants.

Parameters:
- DATA_W, 8, payload width per requester.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating per-source accept counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  global pipeline stall; freezes all state updates except reset.
- req_1  in  1  requester 1 has valid data.
- req_2  in  1  requester 2 has valid data.
- data_1  in  DATA_W  requester 1 payload.
- data_2  in  DATA_W  requester 2 payload.
- grant_1  in  1  arbiter grant to requester 1.
- grant_2  in  1  arbiter grant to requester 2.
- ack_1  out  1  requester 1 payload accepted this cycle.
- ack_2  out  1  requester 2 payload accepted this cycle.
- out_valid  out  1  head entry valid.
- out_data  out  DATA_W  head payload.
- out_src  out  1  head source: 0 = requester 1, 1 = requester 2.
- out_ready  in  1  downstream accepts head.
- count  out  clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- acc_cnt_1  out  CNT_W  saturating accept count, source 1.
- acc_cnt_2  out  CNT_W  saturating accept count, source 2.
- dbl_err  out  1  sticky: both grants seen high together.

Behaviour:
- Reset (reset == 0, asynchronous) clears:
  - read pointer, write pointer, count, acc_cnt_1, acc_cnt_2 and dbl_err to 0.
  - Outputs then read out_valid = 0, empty = 1, full = 0, out_data = 0, out_src = 0, ack_1 = ack_2 = 0.
  - FIFO storage need not be reset.
- Reset mid-operation discards all queued entries immediately. The first push after reset release lands in slot 0.
- dgnt = grant_1 & grant_2.
- push_1 = grant_1 & req_1 & ~grant_2 & ~full & ~stall; push_2 is symmetric. At most one push per cycle.
- ack_x = push_x, combinational, same cycle. A payload is enqueued at the rising edge ending the ack cycle.
- Grant without matching request causes no push, no ack and no error.
- dgnt high:
  - No push that cycle.
  - dbl_err is set at the next edge unless stall is high. It stays set until reset.
  - dbl_err does not block later pushes.
- pop = out_valid & out_ready & ~stall. The head advances at the edge.
- out_valid = ~empty.
- out_data/out_src:
  - Combinational from the head slot.
  - Forced to 0 when empty.
  - Held stable while out_valid & ~out_ready, or while stalled.
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N (same cycle as count update). There is no combinational bypass from input to output.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full blocks push even if a pop occurs in the same cycle. Empty never pops.
- Pointers wrap modulo DEPTH. count is updated as count + push − pop.
- acc_cnt_x increments on each push_x and saturates at 2^CNT_W − 1; it never wraps.
- stall high:
  - ack_1 = ack_2 = 0.
  - No pointer, count, counter or dbl_err change.
  - Outputs hold.

Test Plan:
- Reset: drive reset = 0 mid-run with count = 3 -> out_valid = 0, empty = 1, count = 0, dbl_err = 0, acc counts 0. After release, push 0x5A from source 1 -> out_data = 0x5A, out_src = 0 one edge later.
- Fill/backpressure (DEPTH = 4, out_ready = 0): alternate grants pushing 0x11, 0x22, 0x33, 0x44 -> full = 1, count = 4. A fifth grant gets ack = 0. Then out_ready = 1 drains 0x11, 0x22, 0x33, 0x44 with out_src 0, 1, 0, 1.
- Simultaneous push/pop at count = 2 for 6 cycles -> count stays 2, order preserved, pointers wrap correctly.
- Double grant: grant_1 = grant_2 = 1 with both req -> ack_1 = ack_2 = 0, count unchanged, dbl_err = 1 next edge and still 1 after 10 normal pushes.
- Stall: with count = 2 and out_ready = 1, hold stall = 1 for 3 cycles with grant_1 & req_1 -> no ack, count = 2, out_data unchanged. On stall release, push and pop resume the same cycle.
- Saturation (CNT_W = 3 override): 9 accepted pushes from source 2 -> acc_cnt_2 = 7, acc_cnt_1 = 0.

Source files
------------

// File: rtl/grant_queue.sv
// grant_queue: captures the arbiter's winning payload into a small FIFO,
// tagged with its source, and hands it downstream over valid/ready.
// Also keeps saturating per-source accept counts and a sticky
// double-grant error flag. A global stall freezes every state update.
module grant_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      req_1,
    input  logic                      req_2,
    input  logic [DATA_W-1:0]         data_1,
    input  logic [DATA_W-1:0]         data_2,
    input  logic                      grant_1,
    input  logic                      grant_2,
    output logic                      ack_1,
    output logic                      ack_2,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_src,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [CNT_W-1:0]          acc_cnt_1,
    output logic [CNT_W-1:0]          acc_cnt_2,
    output logic                      dbl_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

    // Accept counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_src  [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_acc_1;
    logic [CNT_W-1:0]  r_acc_2;
    logic              r_dbl_err;

    logic              w_full;
    logic              w_empty;
    logic              w_dgnt;
    logic              w_push_1;
    logic              w_push_2;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wsrc;

    assign w_full   = (r_count == OCC_FULL);
    assign w_empty  = (r_count == '0);
    assign w_dgnt   = grant_1 & grant_2;

    // A double grant never pushes; reset is folded in so no ack leaks
    // out while the queue is being cleared.
    assign w_push_1 = grant_1 & req_1 & ~grant_2 & ~w_full & ~stall & reset;
    assign w_push_2 = grant_2 & req_2 & ~grant_1 & ~w_full & ~stall & reset;
    assign w_push   = w_push_1 | w_push_2;
    assign w_pop    = ~w_empty & out_ready & ~stall;
    assign w_wdata  = w_push_2 ? data_2 : data_1;
    assign w_wsrc   = w_push_2;

    // Payload storage: written only on push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_wdata;
            r_mem_src[r_wr_ptr]  <= w_wsrc;
        end
    end

    // Pointers and occupancy; stall is already folded into push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-source accept counters and the sticky double-grant flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_1   <= '0;
            r_acc_2   <= '0;
            r_dbl_err <= 1'b0;
        end else begin
            if (w_push_1) r_acc_1 <= sat_inc(r_acc_1);
            if (w_push_2) r_acc_2 <= sat_inc(r_acc_2);
            if (w_dgnt && !stall) r_dbl_err <= 1'b1;
        end
    end

    assign ack_1     = w_push_1;
    assign ack_2     = w_push_2;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign out_src   = w_empty ? 1'b0 : r_mem_src[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign acc_cnt_1 = r_acc_1;
    assign acc_cnt_2 = r_acc_2;
    assign dbl_err   = r_dbl_err;

endmodule

// File: tb/tb_grant_queue.sv
// Testbench for grant_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_grant_queue;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              req_1, req_2;
    logic [DATA_W-1:0] data_1, data_2;
    logic              grant_1, grant_2;
    logic              ack_1, ack_2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;
    logic [2:0]        count;
    logic              full, empty;
    logic [CNT_W-1:0]  acc_cnt_1, acc_cnt_2;
    logic              dbl_err;

    int vectors   = 0;
    int miscompares = 0;
    bit chk_en    = 1'b0;

    grant_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_1(req_1), .req_2(req_2), .data_1(data_1), .data_2(data_2),
        .grant_1(grant_1), .grant_2(grant_2),
        .ack_1(ack_1), .ack_2(ack_2),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .count(count), .full(full), .empty(empty),
        .acc_cnt_1(acc_cnt_1), .acc_cnt_2(acc_cnt_2), .dbl_err(dbl_err)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of {src, data} plus counters.
    logic [8:0] mq[$];
    int         m_acc1 = 0;
    int         m_acc2 = 0;
    bit         m_dbl  = 1'b0;

    function automatic bit exp_push1();
        return reset && !stall && grant_1 && req_1 && !grant_2 && (mq.size() < DEPTH);
    endfunction

    function automatic bit exp_push2();
        return reset && !stall && grant_2 && req_2 && !grant_1 && (mq.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_acc1 = 0;
            m_acc2 = 0;
            m_dbl  = 1'b0;
        end else if (!stall) begin
            bit p1, p2, pp;
            p1 = exp_push1();
            p2 = exp_push2();
            pp = (mq.size() > 0) && out_ready;
            if (grant_1 && grant_2) m_dbl = 1'b1;
            if (pp) void'(mq.pop_front());
            if (p1) begin
                mq.push_back({1'b0, data_1});
                if (m_acc1 < CNT_MAX) m_acc1++;
            end
            if (p2) begin
                mq.push_back({1'b1, data_2});
                if (m_acc2 < CNT_MAX) m_acc2++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_v, act_v;
            logic [8:0]  head;
            head  = (mq.size() > 0) ? mq[0] : 9'h0;
            exp_v = {exp_push1(), exp_push2(), (mq.size() > 0), head[7:0], head[8],
                     3'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0),
                     3'(m_acc1), 3'(m_acc2), m_dbl};
            act_v = {ack_1, ack_2, out_valid, out_data, out_src, count, full, empty,
                     acc_cnt_1, acc_cnt_2, dbl_err};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t: got %08h expected %08h (ack1,ack2,vld,data,src,cnt,full,empty,acc1,acc2,dbl)",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        grant_1 = 0; grant_2 = 0; req_1 = 0; req_2 = 0;
    endtask

    task automatic drive(input bit src2, input logic [7:0] d);
        idle();
        if (src2) begin grant_2 = 1; req_2 = 1; data_2 = d; end
        else      begin grant_1 = 1; req_1 = 1; data_1 = d; end
    endtask

    task automatic drain();
        idle();
        out_ready = 1;
        repeat (DEPTH + 1) tick();
        out_ready = 0;
    endtask

    logic [7:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] pp_heads  [6] = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13};

    initial begin
        reset = 0; stall = 0; out_ready = 0;
        data_1 = 0; data_2 = 0;
        idle();
        tick();
        chk_en = 1;
        tick();

        // Reset state
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_data", out_data, 0);
        check("rst_dbl", dbl_err, 0);
        tick();
        reset = 1;
        tick();

        // Fill under backpressure, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(i % 2, fill_vals[i]);
            tick();
        end
        idle();
        @(negedge clk);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        tick();
        drive(0, 8'h55);
        @(negedge clk);
        check("fifth_ack", ack_1, 0);
        tick();
        idle();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_data", out_data, fill_vals[i]);
            check("drain_src", out_src, i % 2);
            tick();
        end
        out_ready = 0;
        @(negedge clk);
        check("drain_empty", empty, 1);
        tick();

        // Simultaneous push and pop at occupancy 2
        drive(0, 8'h01); tick();
        drive(0, 8'h02); tick();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(i % 2, 8'(8'h10 + i));
            @(negedge clk);
            check("pp_count", count, 2);
            check("pp_head", out_data, pp_heads[i]);
            tick();
        end
        drain();

        // Double grant
        grant_1 = 1; grant_2 = 1; req_1 = 1; req_2 = 1;
        data_1 = 8'hD1; data_2 = 8'hD2;
        @(negedge clk);
        check("dg_ack1", ack_1, 0);
        check("dg_ack2", ack_2, 0);
        tick();
        idle();
        @(negedge clk);
        check("dg_dbl", dbl_err, 1);
        check("dg_count", count, 0);
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            drive(i % 2, 8'(8'h60 + i));
            tick();
        end
        idle();
        @(negedge clk);
        check("dg_sticky", dbl_err, 1);
        drain();

        // Stall with occupancy 2
        drive(0, 8'hA1); tick();
        drive(1, 8'hA2); tick();
        stall = 1;
        out_ready = 1;
        drive(0, 8'hB1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_ack", ack_1, 0);
            check("st_count", count, 2);
            check("st_data", out_data, 8'hA1);
            tick();
        end
        stall = 0;
        @(negedge clk);
        check("st_rel_ack", ack_1, 1);
        tick();
        idle();
        @(negedge clk);
        check("st_rel_count", count, 2);
        check("st_rel_data", out_data, 8'hA2);
        drain();

        // Reset mid-run with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'(8'hC0 + i));
            tick();
        end
        idle();
        @(negedge clk);
        check("pre_rst_count", count, 3);
        tick();
        reset = 0;
        @(negedge clk);
        check("mr_valid", out_valid, 0);
        check("mr_empty", empty, 1);
        check("mr_count", count, 0);
        check("mr_dbl", dbl_err, 0);
        check("mr_acc1", acc_cnt_1, 0);
        check("mr_acc2", acc_cnt_2, 0);
        tick();
        reset = 1;
        drive(0, 8'h5A);
        tick();
        idle();
        @(negedge clk);
        check("post_rst_data", out_data, 8'h5A);
        check("post_rst_src", out_src, 0);
        tick();

        // Accept counter saturation
        reset = 0;
        tick();
        reset = 1;
        out_ready = 1;
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'(i));
            tick();
        end
        idle();
        @(negedge clk);
        check("sat_acc2", acc_cnt_2, 7);
        check("sat_acc1", acc_cnt_1, 0);
        tick();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
